// File: rtl/sdram_client_port.sv
// Client-side port for an SDRAM controller: packs requests into command-FIFO
// words, tracks outstanding reads and returns read data in command order.
module sdram_client_port #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [23:0] req_addr_i,
    input  logic [15:0] req_data_i,
    input  logic [1:0]  req_sel_i,
    output logic [42:0] cmd_d_o,
    output logic        cmd_enq_o,
    input  logic        cmd_full_i,
    input  logic [15:0] rd_q_i,
    input  logic        rd_empty_i,
    output logic        rd_deq_o,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    input  logic        rsp_ready_i,
    output logic        busy_o,
    output logic        stray_o
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, ENQ} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_outstanding;
    logic        w_accept;
    logic        w_rd_accept;
    logic        w_pop_valid;
    logic        w_pop_stray;
    logic [42:0] w_cmd;

    always_comb begin
        req_ready_o = (r_state == IDLE) && !cmd_full_i &&
                      (req_we_i || (r_outstanding < MAX_CNT));
        w_accept    = req_valid_i && req_ready_o;
        w_rd_accept = w_accept && !req_we_i;
        rd_deq_o    = !rd_empty_i && (!rsp_valid_o || rsp_ready_i);
        w_pop_valid = rd_deq_o && (r_outstanding != 8'd0);
        w_pop_stray = rd_deq_o && (r_outstanding == 8'd0);
        busy_o      = (r_outstanding != 8'd0) || (r_state == ENQ);
        if (req_we_i) begin
            w_cmd = {1'b1, req_sel_i, req_addr_i, req_data_i};
        end else begin
            w_cmd = {1'b0, 2'b11, req_addr_i, 16'h0000};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ENQ;
            ENQ:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            cmd_enq_o <= 1'b0;
            cmd_d_o   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            cmd_enq_o <= w_accept;
            if (w_accept) begin
                cmd_d_o <= w_cmd;
            end
        end
    end

    // A read accepted in the same cycle as a counted pop cancels out.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_accept, w_pop_valid})
                2'b10: if (r_outstanding != 8'hFF) r_outstanding <= r_outstanding + 8'd1;
                2'b01: r_outstanding <= r_outstanding - 8'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            stray_o     <= 1'b0;
        end else begin
            if (w_pop_valid) begin
                rsp_valid_o <= 1'b1;
                rsp_data_o  <= rd_q_i;
            end else if (rsp_valid_o && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
            if (w_pop_stray) begin
                stray_o <= 1'b1;
            end
        end
    end

endmodule
